// File: rtl/vga_timing.sv
// Raster timing generator: pixel divider, row/col counters, sync pulses and blanking flags.
// Optional `VGA_FRAME_COUNT_EN adds a 16-bit frame counter output (frame_cnt).
module vga_timing #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned CLK_DIV     = 2,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] row,
  output logic [31:0] col,
  output logic        hsync,
  output logic        vsync,
  output logic        vnotactive,
  output logic        de,
  output logic        pix_en,
  output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned HTotal     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HSyncFirst = H_ACTIVE + H_FP;
  localparam int unsigned HSyncLast  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned VSyncFirst = V_ACTIVE + V_FP;
  localparam int unsigned VSyncLast  = V_ACTIVE + V_FP + V_SYNC - 1;

  logic [31:0] div_cnt_q, div_cnt_d;
  logic [31:0] row_q, row_d;
  logic [31:0] col_q, col_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        vnot_q, vnot_d;
  logic        de_q, de_d;
  logic        pix_en_q, pix_en_d;
  logic        frame_start_q, frame_start_d;
  logic        tick;

  assign tick = (div_cnt_q == CLK_DIV - 1);

  always_comb begin
    div_cnt_d     = div_cnt_q + 32'd1;
    row_d         = row_q;
    col_d         = col_q;
    pix_en_d      = 1'b0;
    frame_start_d = 1'b0;
    if (tick) begin
      div_cnt_d = 32'd0;
      pix_en_d  = 1'b1;
      if (col_q == HTotal - 1) begin
        col_d = 32'd0;
        if (row_q == VTotal - 1) begin
          row_d         = 32'd0;
          frame_start_d = 1'b1;
        end else begin
          row_d = row_q + 32'd1;
        end
      end else begin
        col_d = col_q + 32'd1;
      end
    end
    // Flags come from the next counter values so they switch on the same edge as row/col.
    hsync_d = (col_d >= HSyncFirst && col_d <= HSyncLast) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d = (row_d >= VSyncFirst && row_d <= VSyncLast) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vnot_d  = (row_d >= V_ACTIVE);
    de_d    = (col_d < H_ACTIVE) && (row_d < V_ACTIVE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_cnt_q     <= 32'd0;
      row_q         <= 32'd0;
      col_q         <= 32'd0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      vnot_q        <= 1'b0;
      de_q          <= 1'b1;
      pix_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      row_q         <= row_d;
      col_q         <= col_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vnot_q        <= vnot_d;
      de_q          <= de_d;
      pix_en_q      <= pix_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign row         = row_q;
  assign col         = col_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vnotactive  = vnot_q;
  assign de          = de_q;
  assign pix_en      = pix_en_q;
  assign frame_start = frame_start_q;

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      frame_cnt_q <= 16'd0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing using a shrunken raster (16x12 totals) so frames are short.
// Instance a runs CLK_DIV=2, instance b runs CLK_DIV=1; both share clock and reset.
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] row_a, col_a, row_b, col_b;
  logic hs_a, vs_a, vn_a, de_a, pe_a, fs_a;
  logic hs_b, vs_b, vn_b, de_b, pe_b, fs_b;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fc_a, fc_b;
`endif

  int checks = 0;
  int failures = 0;

  // Shrunken raster: H 8+2+3+3=16, V 6+2+2+2=12; hsync low cols 10..12, vsync low rows 8..9.
  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(2), .SYNC_ACTIVE(1'b0)
  ) u_dut_a (
    .CLK(clk), .RST(rst), .row(row_a), .col(col_a), .hsync(hs_a), .vsync(vs_a),
    .vnotactive(vn_a), .de(de_a), .pix_en(pe_a), .frame_start(fs_a)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(1), .SYNC_ACTIVE(1'b0)
  ) u_dut_b (
    .CLK(clk), .RST(rst), .row(row_b), .col(col_b), .hsync(hs_b), .vsync(vs_b),
    .vnotactive(vn_b), .de(de_b), .pix_en(pe_b), .frame_start(fs_b)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_row"}, row_a, 0);
    check({tag, "_col"}, col_a, 0);
    check({tag, "_hsync"}, 32'(hs_a), 1);
    check({tag, "_vsync"}, 32'(vs_a), 1);
    check({tag, "_vnot"}, 32'(vn_a), 0);
    check({tag, "_de"}, 32'(de_a), 1);
    check({tag, "_pix_en"}, 32'(pe_a), 0);
    check({tag, "_fs"}, 32'(fs_a), 0);
    check({tag, "_b_row"}, row_b, 0);
    check({tag, "_b_pix_en"}, 32'(pe_b), 0);
  endtask

  // Runs n CLKs from a reset release; k counts rising edges since release.
  task automatic run_model(input int n, input int exp_fs_cnt);
    int hs_low = 0, de_low = 0, vs_low = 0, vn_hi = 0, fs_cnt = 0;
    int fs_k0 = 0, fs_k1 = 0;
    for (int k = 1; k <= n; k++) begin
      int p, pos, r, c, pb, cb;
      @(negedge clk);
      p   = k / 2;
      pos = p % 192;
      c   = pos % 16;
      r   = pos / 16;
      check("a_col", col_a, c);
      check("a_row", row_a, r);
      check("a_pix_en", 32'(pe_a), (k % 2 == 0) ? 1 : 0);
      check("a_fs", 32'(fs_a), (k % 2 == 0 && pos == 0) ? 1 : 0);
      check("a_de", 32'(de_a), (c < 8 && r < 6) ? 1 : 0);
      check("a_hsync", 32'(hs_a), (c >= 10 && c <= 12) ? 0 : 1);
      check("a_vsync", 32'(vs_a), (r >= 8 && r <= 9) ? 0 : 1);
      check("a_vnot", 32'(vn_a), (r >= 6) ? 1 : 0);
      pb = k % 192;
      cb = pb % 16;
      check("b_col", col_b, cb);
      check("b_row", row_b, pb / 16);
      check("b_pix_en", 32'(pe_b), 1);
      check("b_fs", 32'(fs_b), (pb == 0) ? 1 : 0);
`ifdef VGA_FRAME_COUNT_EN
      if (k == 576) check("b_frame_cnt", 32'(fc_b), 3);
`endif
      if (k < 384) begin
        if (row_a == 0 && !hs_a) hs_low++;
        if (row_a == 0 && !de_a) de_low++;
        if (!vs_a) vs_low++;
        if (vn_a) vn_hi++;
      end
      if (fs_a) begin
        fs_cnt++;
        if (fs_cnt == 1) fs_k0 = k;
        if (fs_cnt == 2) fs_k1 = k;
      end
    end
    check("row0_hsync_low_clks", hs_low, 6);
    check("row0_de_low_clks", de_low, 16);
    check("frame_vsync_low_clks", vs_low, 64);
    check("frame_vnot_clks", vn_hi, 192);
    check("fs_count", fs_cnt, exp_fs_cnt);
    check("first_fs_clk", fs_k0, 384);
    if (exp_fs_cnt >= 2) check("fs_period", fs_k1 - fs_k0, 384);
  endtask

  initial begin
    int waited;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
`ifdef VGA_FRAME_COUNT_EN
    check("reset_frame_cnt", 32'(fc_b), 0);
`endif
    rst = 1'b1;
    run_model(768, 2);

    waited = 0;
    while (!(row_a == 4 && col_a == 5) && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check("wait_for_4_5", (waited < 1000) ? 1 : 0, 1);
    rst = 1'b0;
    #1;
    check_reset_state("midrst");
    repeat (3) begin
      @(negedge clk);
      check("midrst_hold_col", col_a, 0);
      check("midrst_hold_pix_en", 32'(pe_a), 0);
    end
    rst = 1'b1;
    run_model(400, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
